shared_adder_arbiter: RTL and testbench
=======================================

Name: shared_adder_arbiter

Overview:
- Shares one registered W-bit adder (a + b + carry-in) between NREQ requesters.
- Round-robin arbitration picks at most one operation per cycle.
- The chosen operation is computed and held in a single-entry output register, tagged with the requester id; the consumer can apply back-pressure.
- Replaces per-requester duplicated adders such as the paired "+0"/"+1" sum registers in existing datapaths.

Parameters:
- W, 8, operand/sum width.
- NREQ, 4, number of requesters (2..8).
- IDW, 2, id width; must equal ceil(log2(NREQ)).
- CNTW, 16, width of the completed-operation counter.

Ports:
- clk  in  1  clock.
- reset_  in  1  reset.
- req_valid  in  NREQ  per-requester operation valid.
- req_ready  out  NREQ  per-requester grant / accept, combinational.
- req_a  in  NREQ*W  operand a; requester i occupies bits [i*W +: W].
- req_b  in  NREQ*W  operand b, same packing as req_a.
- req_cin  in  NREQ  carry-in per requester.
- rsp_valid  out  1  result register holds a valid result.
- rsp_ready  in  1  consumer accepts result.
- rsp_id  out  IDW  index of the requester that issued the result.
- rsp_sum  out  W  (a + b + cin) mod 2^W.
- rsp_carry  out  1  bit W of a + b + cin.
- op_count  out  CNTW  completed operations, saturating.

Behaviour:
- Clock and reset: single clock domain, clk. Reset is reset_, asynchronous and active-low; all flops clear immediately on reset_ low, independent of clk.
- Reset values: rsp_valid=0, rsp_id=0, rsp_sum=0, rsp_carry=0, op_count=0, round-robin pointer last=NREQ-1, so requester 0 has top priority after reset.
- slot_free = !rsp_valid || rsp_ready (combinational).
- Arbitration (combinational):
  - When slot_free, grant the first i with req_valid[i]=1, searching from last+1 upward and wrapping modulo NREQ.
  - req_ready[i]=1 only for the granted i; all zero when !slot_free or no request.
  - req_ready must not depend on req_a, req_b or req_cin.
- Handshake and transfer:
  - A transfer happens on a rising edge when req_valid[i] && req_ready[i].
  - Requesters must hold valid and operands stable until accepted.
  - An unaccepted request causes no state change.
- Datapath: on transfer, register sum = req_a[i] + req_b[i] + req_cin[i], computed at W+1 bits.
  - rsp_sum <= sum[W-1:0], rsp_carry <= sum[W], rsp_id <= i, rsp_valid <= 1, last <= i.
- Latency: exactly 1 cycle from accept edge to rsp_valid.
- Throughput: one result per cycle while rsp_ready=1.
- Response drain: rsp_valid && rsp_ready with no new transfer in the same cycle -> rsp_valid <= 0.
- Simultaneous drain and new accept (rsp_ready=1 and a grant in the same cycle) -> the register reloads, rsp_valid stays 1, and no bubble is inserted.
- Stall: rsp_valid && !rsp_ready -> rsp_id, rsp_sum and rsp_carry hold; no grants are issued; last holds.
- Fairness: a continuously requesting requester is granted within NREQ grants.
- Wrap-around arithmetic: 0xFF + 0x00 + 1 -> sum 0x00, carry 1. The maximum case 0xFF + 0xFF + 1 -> sum 0xFF, carry 1.
- op_count:
  - Increments on each response handshake (rsp_valid && rsp_ready).
  - Saturates at 2^CNTW-1 with no wrap.
  - Cleared only by reset.
- Reset mid-operation: a pending result is discarded with no output handshake, and the pointer returns to NREQ-1.
- Requester indices >= NREQ do not exist; there are no X states on unused bits.

Test Plan:
- Single op: reset, then req_valid=0001, a0=0x12, b0=0x34, cin0=1. Required: req_ready=0001; next cycle rsp_valid=1, id=0, sum=0x47, carry=0; op_count=1 after rsp_ready handshake.
- Carry/wrap: requester 2 submits a=0xFF, b=0x01, cin=0 -> sum=0x00, carry=1. Requester 2 then submits a=0xFF, b=0xFF, cin=1 -> sum=0xFF, carry=1.
- Round-robin: all four req_valid held high, rsp_ready=1 -> grant order 0,1,2,3,0,1 on consecutive cycles, one rsp per cycle with matching rsp_id.
- Back-pressure: rsp_ready=0 for 3 cycles while req_valid=1111. Required: req_ready=0000 and rsp_* stable. Release rsp_ready -> drain and new grant in the same cycle, rsp_valid stays 1.
- Async reset mid-stream: assert reset_ low between clock edges while rsp_valid=1. Required: rsp_valid=0 and op_count=0 immediately; after release with req_valid=1010 -> requester 1 is granted first.
- Saturation: CNTW=4, 20 handshakes -> op_count=15 and stays 15.

Source files
------------

// File: rtl/shared_adder_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : shared_adder_arbiter
// Purpose  : Round-robin arbiter sharing one registered W-bit adder between
//            NREQ requesters, with a single-entry tagged result register.
// Revision : 1.0  initial release
// ============================================================================
module shared_adder_arbiter #(
    parameter int W    = 8,
    parameter int NREQ = 4,
    parameter int IDW  = 2,
    parameter int CNTW = 16
) (
    input  logic              clk,
    input  logic              reset_,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    input  logic [NREQ-1:0]   req_cin,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [W-1:0]      rsp_sum,
    output logic              rsp_carry,
    output logic [CNTW-1:0]   op_count
);

    logic           slot_free;
    logic           rsp_hs;
    logic           grant_any;
    logic           hi_found;
    logic           lo_found;
    logic [IDW-1:0] last;
    logic [IDW-1:0] grant_id;
    logic [IDW-1:0] hi_id;
    logic [IDW-1:0] lo_id;
    logic [W-1:0]   a_sel;
    logic [W-1:0]   b_sel;
    logic           cin_sel;
    logic [W:0]     sum;

    assign slot_free = !rsp_valid || rsp_ready;
    assign rsp_hs    = rsp_valid && rsp_ready;

    // Lowest requester above last wins; otherwise lowest at or below last.
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_id    = '0;
        lo_id    = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                if (i > int'(last)) begin
                    hi_found = 1'b1;
                    hi_id    = IDW'(i);
                end else begin
                    lo_found = 1'b1;
                    lo_id    = IDW'(i);
                end
            end
        end
        grant_any = slot_free && (hi_found || lo_found);
        grant_id  = hi_found ? hi_id : lo_id;
    end

    always_comb begin
        req_ready = '0;
        a_sel     = '0;
        b_sel     = '0;
        cin_sel   = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_id == IDW'(i)) begin
                req_ready[i] = grant_any;
                a_sel        = req_a[i*W +: W];
                b_sel        = req_b[i*W +: W];
                cin_sel      = req_cin[i];
            end
        end
    end

    assign sum = {1'b0, a_sel} + {1'b0, b_sel} + {{W{1'b0}}, cin_sel};

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_sum   <= '0;
            rsp_carry <= 1'b0;
            last      <= IDW'(NREQ - 1);
        end else if (grant_any) begin
            rsp_valid <= 1'b1;
            rsp_id    <= grant_id;
            rsp_sum   <= sum[W-1:0];
            rsp_carry <= sum[W];
            last      <= grant_id;
        end else if (rsp_hs) begin
            rsp_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            op_count <= '0;
        end else if (rsp_hs && (op_count != {CNTW{1'b1}})) begin
            op_count <= op_count + CNTW'(1);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_shared_adder_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_shared_adder_arbiter
// Purpose  : Self-checking bench: vector table, round-robin model, scoreboard.
// Revision : 1.0  initial release
// ============================================================================
module tb_shared_adder_arbiter;

    localparam int W    = 8;
    localparam int NREQ = 4;
    localparam int IDW  = 2;
    localparam int CNTW = 4;
    localparam int CMAX = (1 << CNTW) - 1;

    logic              clk;
    logic              reset_;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [NREQ-1:0]   req_cin;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [W-1:0]      rsp_sum;
    logic              rsp_carry;
    logic [CNTW-1:0]   op_count;

    shared_adder_arbiter #(.W(W), .NREQ(NREQ), .IDW(IDW), .CNTW(CNTW)) dut (
        .clk       (clk),
        .reset_    (reset_),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_cin   (req_cin),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_carry (rsp_carry),
        .op_count  (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         id;
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] sum;
        logic       carry;
    } vec_t;

    typedef struct {
        logic [IDW-1:0] id;
        logic [W-1:0]   sum;
        logic           carry;
    } exp_t;

    exp_t            q[$];
    int              checks = 0;
    int              errors = 0;
    logic            m_valid;
    int              m_last;
    int              m_count;
    logic [NREQ-1:0] seen_ready;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic int model_pick(input logic [NREQ-1:0] v, input int lst, input logic free);
        int j;
        if (!free) return -1;
        for (int k = 1; k <= NREQ; k++) begin
            j = (lst + k) % NREQ;
            if (v[j]) return j;
        end
        return -1;
    endfunction

    // One clock: compare at the falling edge, advance the model, return at posedge+1.
    task automatic cycle();
        int         g;
        logic       free;
        exp_t       e;
        logic [W:0] s;
        @(negedge clk);
        free       = !m_valid || rsp_ready;
        g          = model_pick(req_valid, m_last, free);
        seen_ready = req_ready;
        check("req_ready", {28'd0, req_ready}, (g < 0) ? 32'd0 : (32'd1 << g));
        check("rsp_valid", {31'd0, rsp_valid}, {31'd0, m_valid});
        if (m_valid && q.size() > 0) begin
            check("rsp_id", {30'd0, rsp_id}, {30'd0, q[0].id});
            check("rsp_sum", {24'd0, rsp_sum}, {24'd0, q[0].sum});
            check("rsp_carry", {31'd0, rsp_carry}, {31'd0, q[0].carry});
        end
        check("op_count", {28'd0, op_count}, m_count);
        if (m_valid && rsp_ready) begin
            void'(q.pop_front());
            if (m_count != CMAX) m_count++;
        end
        if (g >= 0) begin
            s       = {1'b0, req_a[g*W +: W]} + {1'b0, req_b[g*W +: W]} + {{W{1'b0}}, req_cin[g]};
            e.id    = IDW'(g);
            e.sum   = s[W-1:0];
            e.carry = s[W];
            q.push_back(e);
            m_valid = 1'b1;
            m_last  = g;
        end else if (m_valid && rsp_ready) begin
            m_valid = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    // Asynchronous reset asserted between edges; outputs must clear at once.
    task automatic do_reset();
        #2;
        reset_ = 1'b0;
        #1;
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_op_count", {28'd0, op_count}, 32'd0);
        check("rst_rsp_sum", {24'd0, rsp_sum}, 32'd0);
        check("rst_rsp_id", {30'd0, rsp_id}, 32'd0);
        check("rst_rsp_carry", {31'd0, rsp_carry}, 32'd0);
        req_valid = '0;
        m_valid   = 1'b0;
        m_last    = NREQ - 1;
        m_count   = 0;
        q.delete();
        @(negedge clk);
        reset_ = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
        req_cin[i]      = c;
    endtask

    vec_t vecs[8];
    int   rr_order[6];

    initial begin
        vecs[0] = '{0, 8'h12, 8'h34, 1'b1, 8'h47, 1'b0};
        vecs[1] = '{2, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        vecs[2] = '{2, 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        vecs[3] = '{1, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
        vecs[4] = '{3, 8'h7F, 8'h00, 1'b1, 8'h80, 1'b0};
        vecs[5] = '{0, 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1};
        vecs[6] = '{3, 8'hA5, 8'h5A, 1'b0, 8'hFF, 1'b0};
        vecs[7] = '{1, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
        rr_order = '{0, 1, 2, 3, 0, 1};

        reset_    = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_cin   = '0;
        rsp_ready = 1'b0;
        m_valid   = 1'b0;
        m_last    = NREQ - 1;
        m_count   = 0;
        @(posedge clk);
        #1;
        do_reset();

        // Single operations from the vector table.
        rsp_ready = 1'b1;
        foreach (vecs[n]) begin
            set_op(vecs[n].id, vecs[n].a, vecs[n].b, vecs[n].cin);
            req_valid = '0;
            req_valid[vecs[n].id] = 1'b1;
            cycle();
            req_valid = '0;
            check("vec_valid", {31'd0, rsp_valid}, 32'd1);
            check("vec_id", {30'd0, rsp_id}, vecs[n].id);
            check("vec_sum", {24'd0, rsp_sum}, {24'd0, vecs[n].sum});
            check("vec_carry", {31'd0, rsp_carry}, {31'd0, vecs[n].carry});
            cycle();
        end
        check("vec_op_count", {28'd0, op_count}, 32'd8);

        // Round-robin with all requesters active.
        do_reset();
        for (int i = 0; i < NREQ; i++) set_op(i, W'(8'h10 * (i + 1)), W'(8'h03 + i), i[0]);
        req_valid = '1;
        rsp_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            cycle();
            check("rr_order", {28'd0, seen_ready}, 32'd1 << rr_order[k]);
        end

        // Back-pressure, then simultaneous drain and reload.
        rsp_ready = 1'b0;
        repeat (3) begin
            cycle();
            check("bp_no_grant", {28'd0, seen_ready}, 32'd0);
        end
        rsp_ready = 1'b1;
        cycle();
        check("bp_reload_valid", {31'd0, rsp_valid}, 32'd1);
        req_valid = '0;
        repeat (2) cycle();

        // Reset with a stalled result pending.
        rsp_ready = 1'b0;
        set_op(0, 8'h11, 8'h22, 1'b0);
        req_valid = 4'b0001;
        cycle();
        req_valid = '0;
        cycle();
        do_reset();
        req_valid = 4'b1010;
        rsp_ready = 1'b1;
        cycle();
        check("post_rst_grant", {28'd0, seen_ready}, 32'h2);
        req_valid = '0;
        cycle();

        // Counter saturation.
        do_reset();
        req_valid = '1;
        repeat (21) cycle();
        req_valid = '0;
        cycle();
        check("sat_count", {28'd0, op_count}, CMAX);
        repeat (3) cycle();
        check("sat_hold", {28'd0, op_count}, CMAX);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
